// File: rtl/mx_pkg.sv
// Shared MX quantization definitions: default geometry, scale type and the
// significant-bit helper used to pick a block's shared scale.
package mx_pkg;

    localparam int MX_IN_WIDTH    = 16;
    localparam int MX_K           = 2;
    localparam int MX_MAN_WIDTH   = 7;
    localparam int MX_SCALE_WIDTH = 8;
    localparam int MX_SCALE_BIAS  = 127;
    localparam int MANT_W         = MX_MAN_WIDTH + 1;

    typedef logic [MX_SCALE_WIDTH-1:0] mx_scale_t;

    // Bits needed to hold x as signed: 64 minus the redundant copies of the sign bit.
    function automatic logic [6:0] mx_sig_bits(input logic signed [63:0] x);
        logic [6:0] n;
        logic       done;
        n    = 7'd64;
        done = 1'b0;
        for (int b = 62; b >= 0; b--) begin
            if (!done && (x[b] == x[63])) begin
                n = n - 7'd1;
            end else begin
                done = 1'b1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/mx_stream_quantizer_if.sv
// Element-stream input and MX-block output handshake of the stream quantizer.
interface mx_stream_quantizer_if #(
    parameter int IN_WIDTH    = mx_pkg::MX_IN_WIDTH,
    parameter int K           = mx_pkg::MX_K,
    parameter int MAN_WIDTH   = mx_pkg::MX_MAN_WIDTH,
    parameter int SCALE_WIDTH = mx_pkg::MX_SCALE_WIDTH
);

    logic signed [IN_WIDTH-1:0]  i_data;
    logic                        i_valid;
    logic                        i_last;
    logic                        o_ready;
    logic signed [MAN_WIDTH:0]   o_mant [K];
    logic [SCALE_WIDTH-1:0]      o_scale;
    logic                        o_valid;
    logic                        o_last;
    logic                        i_ready;

    modport master (
        output i_data, i_valid, i_last, i_ready,
        input  o_ready, o_mant, o_scale, o_valid, o_last
    );

    modport slave (
        input  i_data, i_valid, i_last, i_ready,
        output o_ready, o_mant, o_scale, o_valid, o_last
    );

endinterface

// File: rtl/mx_block_scale.sv
// Combinational MX block quantizer: K signed elements in, shared scale and
// K truncated mantissas out. Shift never exceeds what the mantissa can hold.
module mx_block_scale
    import mx_pkg::*;
#(
    parameter int IN_WIDTH    = MX_IN_WIDTH,
    parameter int K           = MX_K,
    parameter int MAN_WIDTH   = MX_MAN_WIDTH,
    parameter int SCALE_WIDTH = MX_SCALE_WIDTH,
    parameter int SCALE_BIAS  = MX_SCALE_BIAS
)(
    input  logic signed [IN_WIDTH-1:0] data [K],
    output logic [SCALE_WIDTH-1:0]     scale,
    output logic signed [MAN_WIDTH:0]  mant [K]
);

    localparam logic [6:0] MANT_BITS = 7'(MAN_WIDTH + 1);

    logic [6:0] max_sig_s;
    logic [6:0] shift_s;

    // Widest element of the block decides the shift for all of them.
    always_comb begin
        max_sig_s = 7'd1;
        for (int i = 0; i < K; i++) begin
            if (mx_sig_bits({{(64-IN_WIDTH){data[i][IN_WIDTH-1]}}, data[i]}) > max_sig_s) begin
                max_sig_s = mx_sig_bits({{(64-IN_WIDTH){data[i][IN_WIDTH-1]}}, data[i]});
            end else begin
                max_sig_s = max_sig_s;
            end
        end
        if (max_sig_s > MANT_BITS) begin
            shift_s = max_sig_s - MANT_BITS;
        end else begin
            shift_s = 7'd0;
        end
        scale = SCALE_WIDTH'(SCALE_BIAS) + SCALE_WIDTH'(shift_s);
    end

    // Arithmetic shift floors negatives; the result always fits MAN_WIDTH+1 bits.
    always_comb begin
        for (int i = 0; i < K; i++) begin
            mant[i] = (MAN_WIDTH+1)'(data[i] >>> shift_s);
        end
    end

endmodule

// File: rtl/mx_stream_quantizer.sv
// Stream-to-MX-block quantizer: buffers K-1 elements, quantizes on the closing
// element and holds the result in an output register with ready/valid handshake.
module mx_stream_quantizer
    import mx_pkg::*;
#(
    parameter int IN_WIDTH    = MX_IN_WIDTH,
    parameter int K           = MX_K,
    parameter int MAN_WIDTH   = MX_MAN_WIDTH,
    parameter int SCALE_WIDTH = MX_SCALE_WIDTH,
    parameter int SCALE_BIAS  = MX_SCALE_BIAS
)(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    mx_stream_quantizer_if.slave bus
);

    localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(K - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam int MAX_SHIFT = (IN_WIDTH > MAN_WIDTH + 1) ? (IN_WIDTH - MAN_WIDTH - 1) : 0;

    if (SCALE_BIAS + MAX_SHIFT > (2 ** SCALE_WIDTH) - 1) begin : g_bias_check
        $error("mx_stream_quantizer: SCALE_BIAS plus maximum shift overflows SCALE_WIDTH");
    end

    logic [CNT_W-1:0]            cnt_r;
    logic signed [IN_WIDTH-1:0]  buf_r   [K];
    logic signed [IN_WIDTH-1:0]  block_s [K];
    logic signed [MAN_WIDTH:0]   mant_s  [K];
    logic signed [MAN_WIDTH:0]   mant_r  [K];
    logic [SCALE_WIDTH-1:0]      scale_s;
    logic [SCALE_WIDTH-1:0]      scale_r;
    logic                        valid_r;
    logic                        last_r;
    logic                        closing_s;
    logic                        drain_s;
    logic                        ready_s;
    logic                        accept_s;
    logic                        load_s;

    // Only a closing element can be refused: it needs the output register free.
    always_comb begin
        closing_s = (cnt_r == LAST_SLOT) || bus.i_last;
        drain_s   = valid_r && bus.i_ready;
        ready_s   = !(valid_r && !bus.i_ready) || !closing_s;
        accept_s  = bus.i_valid && ready_s;
        load_s    = accept_s && closing_s;
    end

    // Block as seen on the closing edge: buffered slots, live element, zero pad.
    always_comb begin
        for (int j = 0; j < K; j++) begin
            if (CNT_W'(j) == cnt_r) begin
                block_s[j] = bus.i_data;
            end else if (CNT_W'(j) < cnt_r) begin
                block_s[j] = buf_r[j];
            end else begin
                block_s[j] = '0;
            end
        end
    end

    mx_block_scale #(
        .IN_WIDTH    (IN_WIDTH),
        .K           (K),
        .MAN_WIDTH   (MAN_WIDTH),
        .SCALE_WIDTH (SCALE_WIDTH),
        .SCALE_BIAS  (SCALE_BIAS)
    ) u_block_scale (
        .data  (block_s),
        .scale (scale_s),
        .mant  (mant_s)
    );

    // Fill counter and element buffer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_r <= '0;
            for (int j = 0; j < K; j++) begin
                buf_r[j] <= '0;
            end
        end else if (accept_s) begin
            if (closing_s) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
                for (int j = 0; j < K; j++) begin
                    if (CNT_W'(j) == cnt_r) begin
                        buf_r[j] <= bus.i_data;
                    end
                end
            end
        end
    end

    // Output register: a load wins over a drain on the same edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            scale_r <= '0;
            for (int j = 0; j < K; j++) begin
                mant_r[j] <= '0;
            end
        end else if (load_s) begin
            valid_r <= 1'b1;
            last_r  <= bus.i_last;
            scale_r <= scale_s;
            mant_r  <= mant_s;
        end else if (drain_s) begin
            valid_r <= 1'b0;
        end
    end

    assign bus.o_ready = ready_s;
    assign bus.o_valid = valid_r;
    assign bus.o_last  = last_r;
    assign bus.o_scale = scale_r;
    assign bus.o_mant  = mant_r;

endmodule
